// File: rtl/reg_file_sb.sv
// ----------------------------------------------------------------------------
// reg_file_sb
// Multi-write-port architectural register file with an integrated busy-bit
// scoreboard. Register 0 is hard-wired to zero and is never busy. Reads are
// combinational, with optional same-cycle write-to-read forwarding (BYPASS).
//
// Ports
//   clk                    : single clock, all state updates on the rising edge
//   rst                    : asynchronous active-high reset (data and busy -> 0)
//   rs1_addr / rs2_addr    : read addresses
//   rs1_rd_en / rs2_rd_en  : read enables (disabled port returns zero / not busy)
//   rs1_data / rs2_data    : read data
//   rs1_busy / rs2_busy    : scoreboard bit of the addressed register
//   wr_en   [NUM_WR]       : per-port write enable
//   wr_addr [NUM_WR*AW]    : packed write addresses, port k at [k*AW +: AW]
//   wr_data [NUM_WR*XLEN]  : packed write data, port k at [k*XLEN +: XLEN]
//   wr_clr  [NUM_WR]       : per-port: the write also retires the busy bit
//   iss_en / iss_rd        : issue, marks iss_rd busy
//   flush                  : clears every busy bit
//   busy_vec [NUM_REGS]    : registered scoreboard state, bit i = register i
// ----------------------------------------------------------------------------
module reg_file_sb #(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   parameter int NUM_WR   = 2,
   parameter int BYPASS   = 1,
   localparam int AW      = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [AW-1:0]            rs1_addr,
   input  logic [AW-1:0]            rs2_addr,
   input  logic                     rs1_rd_en,
   input  logic                     rs2_rd_en,
   output logic [XLEN-1:0]          rs1_data,
   output logic [XLEN-1:0]          rs2_data,
   output logic                     rs1_busy,
   output logic                     rs2_busy,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*AW-1:0]     wr_addr,
   input  logic [NUM_WR*XLEN-1:0]   wr_data,
   input  logic [NUM_WR-1:0]        wr_clr,
   input  logic                     iss_en,
   input  logic [AW-1:0]            iss_rd,
   input  logic                     flush,
   output logic [NUM_REGS-1:0]      busy_vec
);

   // Architectural state
   logic [XLEN-1:0]     regs_q [NUM_REGS];
   logic [XLEN-1:0]     regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   // Per-register write resolution for the current cycle
   logic [NUM_WR-1:0]   wr_sel_s [NUM_REGS];
   logic [NUM_REGS-1:0] wr_hit_s;
   logic [NUM_REGS-1:0] wr_clr_s;
   logic [XLEN-1:0]     wr_val_s [NUM_REGS];

   // Decode which write ports target each register (register 0 never selected)
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         for (int k = 0; k < NUM_WR; k++) begin
            wr_sel_s[i][k] = wr_en[k] && (wr_addr[k*AW +: AW] == AW'(i)) && (i != 0);
         end
      end
   end

   // Pick the winning port per register: later ports overwrite earlier ones,
   // so the highest-index port supplies both the data and the clear flag.
   always_comb begin
      wr_hit_s = '0;
      wr_clr_s = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         wr_val_s[i] = '0;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
         for (int k = 0; k < NUM_WR; k++) begin
            wr_hit_s[i] = wr_hit_s[i] | wr_sel_s[i][k];
            wr_val_s[i] = wr_sel_s[i][k] ? wr_data[k*XLEN +: XLEN] : wr_val_s[i];
            wr_clr_s[i] = wr_sel_s[i][k] ? wr_clr[k] : wr_clr_s[i];
         end
      end
   end

   // Next-state for register contents
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         if (wr_hit_s[i]) begin
            regs_d[i] = wr_val_s[i];
         end else begin
            regs_d[i] = regs_q[i];
         end
      end
      regs_d[0] = '0;
   end

   // Next-state for the scoreboard: flush beats everything, an issue beats a
   // same-cycle clear because the new producer is still outstanding.
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (flush) begin
            busy_d[i] = 1'b0;
         end else if (iss_en && (iss_rd == AW'(i)) && (i != 0)) begin
            busy_d[i] = 1'b1;
         end else if (wr_hit_s[i] && wr_clr_s[i]) begin
            busy_d[i] = 1'b0;
         end else begin
            busy_d[i] = busy_q[i];
         end
      end
      busy_d[0] = 1'b0;
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
         busy_q <= busy_d;
      end
   end

   // Read port 1: reset and disabled reads return zero; forwarding only when
   // BYPASS is enabled (wr_hit_s is never set for register 0).
   always_comb begin
      if (rst || !rs1_rd_en) begin
         rs1_data = '0;
         rs1_busy = 1'b0;
      end else if ((BYPASS != 0) && wr_hit_s[rs1_addr]) begin
         rs1_data = wr_val_s[rs1_addr];
         rs1_busy = busy_q[rs1_addr] & ~wr_clr_s[rs1_addr];
      end else begin
         rs1_data = regs_q[rs1_addr];
         rs1_busy = busy_q[rs1_addr];
      end
   end

   // Read port 2: same behaviour as port 1
   always_comb begin
      if (rst || !rs2_rd_en) begin
         rs2_data = '0;
         rs2_busy = 1'b0;
      end else if ((BYPASS != 0) && wr_hit_s[rs2_addr]) begin
         rs2_data = wr_val_s[rs2_addr];
         rs2_busy = busy_q[rs2_addr] & ~wr_clr_s[rs2_addr];
      end else begin
         rs2_data = regs_q[rs2_addr];
         rs2_busy = busy_q[rs2_addr];
      end
   end

   // Scoreboard view is registered state only; busy_q is already zero in reset
   assign busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// ----------------------------------------------------------------------------
// tb_reg_file_sb
// Directed vector table, hand-written reset sequences and a randomized run
// against a rule-level reference model. A second instance with BYPASS=0
// shares every input so the no-forwarding behaviour is checked alongside.
// ----------------------------------------------------------------------------
module tb_reg_file_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs1_addr, rs2_addr;
   logic        rs1_rd_en, rs2_rd_en;
   logic [31:0] rs1_data, rs2_data, nb_rs1_data, nb_rs2_data;
   logic        rs1_busy, rs2_busy, nb_rs1_busy, nb_rs2_busy;
   logic [31:0] busy_vec, nb_busy_vec;
   logic        iss_en, flush;
   logic [4:0]  iss_rd;

   logic [1:0]  we, clr;
   logic [4:0]  a0, a1;
   logic [31:0] d0, d1;
   logic [1:0]  wr_en, wr_clr;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;

   assign wr_en   = we;
   assign wr_clr  = clr;
   assign wr_addr = {a1, a0};
   assign wr_data = {d1, d0};

   always #5 clk = ~clk;

   reg_file_sb #(.XLEN(32), .NUM_REGS(32), .NUM_WR(2), .BYPASS(1)) dut (
      .clk(clk), .rst(rst),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_rd_en(rs1_rd_en), .rs2_rd_en(rs2_rd_en),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
      .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush), .busy_vec(busy_vec)
   );

   reg_file_sb #(.XLEN(32), .NUM_REGS(32), .NUM_WR(2), .BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_rd_en(rs1_rd_en), .rs2_rd_en(rs2_rd_en),
      .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data),
      .rs1_busy(nb_rs1_busy), .rs2_busy(nb_rs2_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
      .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush), .busy_vec(nb_busy_vec)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_reg  [32];
   bit          m_busy [32];
   bit          pend_v [32];
   bit          pend_c [32];
   logic [31:0] pend_d [32];

   function automatic void model_reset();
      for (int a = 0; a < 32; a++) begin
         m_reg[a] = 32'h0;
         m_busy[a] = 1'b0;
      end
   endfunction

   // Pending writes this cycle; port 1 is applied after port 0 so it wins.
   function automatic void model_pend();
      for (int a = 0; a < 32; a++) begin
         pend_v[a] = 1'b0;
         pend_c[a] = 1'b0;
         pend_d[a] = 32'h0;
      end
      if (we[0] && a0 != 5'd0) begin pend_v[a0] = 1'b1; pend_d[a0] = d0; pend_c[a0] = clr[0]; end
      if (we[1] && a1 != 5'd0) begin pend_v[a1] = 1'b1; pend_d[a1] = d1; pend_c[a1] = clr[1]; end
   endfunction

   function automatic logic [31:0] exp_data(input logic [4:0] a, input logic en, input bit byp);
      if (!en || a == 5'd0) return 32'h0;
      if (byp && pend_v[a]) return pend_d[a];
      return m_reg[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a, input logic en, input bit byp);
      if (!en) return 1'b0;
      if (byp && pend_v[a] && pend_c[a]) return 1'b0;
      return m_busy[a];
   endfunction

   function automatic logic [31:0] exp_vec();
      logic [31:0] v = 32'h0;
      for (int a = 0; a < 32; a++) v[a] = m_busy[a];
      return v;
   endfunction

   function automatic void model_commit();
      for (int a = 0; a < 32; a++) if (pend_v[a]) m_reg[a] = pend_d[a];
      if (flush) begin
         for (int a = 0; a < 32; a++) m_busy[a] = 1'b0;
      end else begin
         for (int a = 0; a < 32; a++) if (pend_v[a] && pend_c[a]) m_busy[a] = 1'b0;
         if (iss_en && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
      end
   endfunction

   task automatic idle();
      we = 2'b00; clr = 2'b00; a0 = 5'd0; a1 = 5'd0; d0 = 32'h0; d1 = 32'h0;
      iss_en = 1'b0; iss_rd = 5'd0; flush = 1'b0;
      rs1_addr = 5'd0; rs1_rd_en = 1'b0; rs2_addr = 5'd0; rs2_rd_en = 1'b0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [1:0]  we;  logic [4:0] a0; logic [4:0] a1;
      logic [31:0] d0;  logic [31:0] d1; logic [1:0] clr;
      logic        ie;  logic [4:0] ird; logic fl;
      logic [4:0]  r1a; logic r1e; logic [4:0] r2a; logic r2e;
      logic [31:0] x_r1; logic x_b1; logic [31:0] x_r2; logic x_b2;
      logic [31:0] x_bv; logic [31:0] x_nb1;
   } vec_t;

   vec_t tbl [21];

   initial begin
      // we  a0 a1  d0  d1  clr ie ird fl r1a r1e r2a r2e  x_r1 b1 x_r2 b2 bv nb1
      tbl[0]  = '{2'd0,5'd0,5'd0,32'h0,32'h0,2'd0, 1'b0,5'd0,1'b0, 5'd1,1'b1,5'd31,1'b1, 32'h0,1'b0,32'h0,1'b0,32'h0,32'h0};
      tbl[1]  = '{2'd3,5'd5,5'd5,32'hAAAA_0000,32'h5555_1111,2'd0, 1'b0,5'd0,1'b0, 5'd5,1'b1,5'd0,1'b0, 32'h5555_1111,1'b0,32'h0,1'b0,32'h0,32'h0};
      tbl[2]  = '{2'd0,5'd0,5'd0,32'h0,32'h0,2'd0, 1'b0,5'd0,1'b0, 5'd5,1'b1,5'd5,1'b1, 32'h5555_1111,1'b0,32'h5555_1111,1'b0,32'h0,32'h5555_1111};
      tbl[3]  = '{2'd0,5'd0,5'd0,32'h0,32'h0,2'd0, 1'b1,5'd7,1'b0, 5'd7,1'b1,5'd0,1'b0, 32'h0,1'b0,32'h0,1'b0,32'h0,32'h0};
      tbl[4]  = '{2'd0,5'd0,5'd0,32'h0,32'h0,2'd0, 1'b0,5'd0,1'b0, 5'd7,1'b1,5'd0,1'b0, 32'h0,1'b1,32'h0,1'b0,32'h80,32'h0};
      tbl[5]  = '{2'd1,5'd7,5'd0,32'h1234_5678,32'h0,2'd1, 1'b0,5'd0,1'b0, 5'd7,1'b1,5'd0,1'b0, 32'h1234_5678,1'b0,32'h0,1'b0,32'h80,32'h0};
      tbl[6]  = '{2'd0,5'd0,5'd0,32'h0,32'h0,2'd0, 1'b0,5'd0,1'b0, 5'd7,1'b1,5'd0,1'b0, 32'h1234_5678,1'b0,32'h0,1'b0,32'h0,32'h1234_5678};
      tbl[7]  = '{2'd0,5'd0,5'd0,32'h0,32'h0,2'd0, 1'b1,5'd9,1'b0, 5'd9,1'b1,5'd0,1'b0, 32'h0,1'b0,32'h0,1'b0,32'h0,32'h0};
      tbl[8]  = '{2'd2,5'd0,5'd9,32'h0,32'hCAFE_F00D,2'd2, 1'b1,5'd9,1'b0, 5'd9,1'b1,5'd0,1'b0, 32'hCAFE_F00D,1'b0,32'h0,1'b0,32'h200,32'h0};
      tbl[9]  = '{2'd0,5'd0,5'd0,32'h0,32'h0,2'd0, 1'b0,5'd0,1'b0, 5'd9,1'b1,5'd0,1'b0, 32'hCAFE_F00D,1'b1,32'h0,1'b0,32'h200,32'hCAFE_F00D};
      tbl[10] = '{2'd1,5'd0,5'd0,32'hDEAD_BEEF,32'h0,2'd0, 1'b1,5'd0,1'b0, 5'd0,1'b1,5'd5,1'b0, 32'h0,1'b0,32'h0,1'b0,32'h200,32'h0};
      tbl[11] = '{2'd0,5'd0,5'd0,32'h0,32'h0,2'd0, 1'b0,5'd0,1'b0, 5'd0,1'b1,5'd9,1'b1, 32'h0,1'b0,32'hCAFE_F00D,1'b1,32'h200,32'h0};
      tbl[12] = '{2'd0,5'd0,5'd0,32'h0,32'h0,2'd0, 1'b1,5'd3,1'b0, 5'd0,1'b0,5'd0,1'b0, 32'h0,1'b0,32'h0,1'b0,32'h200,32'h0};
      tbl[13] = '{2'd0,5'd0,5'd0,32'h0,32'h0,2'd0, 1'b1,5'd4,1'b0, 5'd0,1'b0,5'd0,1'b0, 32'h0,1'b0,32'h0,1'b0,32'h208,32'h0};
      tbl[14] = '{2'd2,5'd0,5'd3,32'h0,32'h0000_0033,2'd0, 1'b1,5'd6,1'b1, 5'd3,1'b1,5'd0,1'b0, 32'h33,1'b1,32'h0,1'b0,32'h218,32'h0};
      tbl[15] = '{2'd0,5'd0,5'd0,32'h0,32'h0,2'd0, 1'b0,5'd0,1'b0, 5'd3,1'b1,5'd6,1'b1, 32'h33,1'b0,32'h0,1'b0,32'h0,32'h33};
      tbl[16] = '{2'd0,5'd0,5'd0,32'h0,32'h0,2'd0, 1'b1,5'd9,1'b0, 5'd0,1'b0,5'd0,1'b0, 32'h0,1'b0,32'h0,1'b0,32'h0,32'h0};
      tbl[17] = '{2'd3,5'd9,5'd9,32'h1111,32'h2222,2'd1, 1'b0,5'd0,1'b0, 5'd9,1'b1,5'd0,1'b0, 32'h2222,1'b1,32'h0,1'b0,32'h200,32'hCAFE_F00D};
      tbl[18] = '{2'd0,5'd0,5'd0,32'h0,32'h0,2'd0, 1'b0,5'd0,1'b0, 5'd9,1'b1,5'd0,1'b0, 32'h2222,1'b1,32'h0,1'b0,32'h200,32'h2222};
      tbl[19] = '{2'd3,5'd9,5'd9,32'h3333,32'h4444,2'd2, 1'b0,5'd0,1'b0, 5'd9,1'b1,5'd0,1'b0, 32'h4444,1'b0,32'h0,1'b0,32'h200,32'h2222};
      tbl[20] = '{2'd0,5'd0,5'd0,32'h0,32'h0,2'd0, 1'b0,5'd0,1'b0, 5'd9,1'b1,5'd0,1'b0, 32'h4444,1'b0,32'h0,1'b0,32'h0,32'h4444};
   end

   initial begin
      idle();
      rst = 1'b1;
      // reset held with an enabled write and reads: outputs must stay zero
      @(negedge clk);
      we = 2'b01; a0 = 5'd5; d0 = 32'h0BAD_0BAD; iss_en = 1'b1; iss_rd = 5'd5;
      rs1_addr = 5'd5; rs1_rd_en = 1'b1; rs2_addr = 5'd1; rs2_rd_en = 1'b1;
      #2;
      chk("rst_rs1_data", {32'h0, rs1_data}, 64'h0);
      chk("rst_rs1_busy", {63'h0, rs1_busy}, 64'h0);
      chk("rst_busy_vec", {32'h0, busy_vec}, 64'h0);
      @(negedge clk);
      idle();
      rst = 1'b0;

      // directed table
      for (int i = 0; i < 21; i++) begin
         we = tbl[i].we; a0 = tbl[i].a0; a1 = tbl[i].a1; d0 = tbl[i].d0; d1 = tbl[i].d1;
         clr = tbl[i].clr; iss_en = tbl[i].ie; iss_rd = tbl[i].ird; flush = tbl[i].fl;
         rs1_addr = tbl[i].r1a; rs1_rd_en = tbl[i].r1e; rs2_addr = tbl[i].r2a; rs2_rd_en = tbl[i].r2e;
         #2;
         chk($sformatf("v%0d_rs1_data", i), {32'h0, rs1_data}, {32'h0, tbl[i].x_r1});
         chk($sformatf("v%0d_rs1_busy", i), {63'h0, rs1_busy}, {63'h0, tbl[i].x_b1});
         chk($sformatf("v%0d_rs2_data", i), {32'h0, rs2_data}, {32'h0, tbl[i].x_r2});
         chk($sformatf("v%0d_rs2_busy", i), {63'h0, rs2_busy}, {63'h0, tbl[i].x_b2});
         chk($sformatf("v%0d_busy_vec", i), {32'h0, busy_vec}, {32'h0, tbl[i].x_bv});
         chk($sformatf("v%0d_nb_rs1_data", i), {32'h0, nb_rs1_data}, {32'h0, tbl[i].x_nb1});
         @(negedge clk);
      end

      // asynchronous reset between edges
      idle();
      iss_en = 1'b1; iss_rd = 5'd10;
      @(negedge clk);
      idle();
      we = 2'b01; a0 = 5'd9; d0 = 32'h5A5A_5A5A;
      rs1_addr = 5'd9; rs1_rd_en = 1'b1; rs2_addr = 5'd10; rs2_rd_en = 1'b1;
      #2;
      chk("pre_rst_rs1_bypass", {32'h0, rs1_data}, 64'h5A5A_5A5A);
      chk("pre_rst_rs2_busy", {63'h0, rs2_busy}, 64'h1);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_rs1_data", {32'h0, rs1_data}, 64'h0);
      chk("mid_rst_rs2_busy", {63'h0, rs2_busy}, 64'h0);
      chk("mid_rst_busy_vec", {32'h0, busy_vec}, 64'h0);
      chk("mid_rst_nb_rs1", {32'h0, nb_rs1_data}, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      idle();
      we = 2'b01; a0 = 5'd9; d0 = 32'h0000_0077;
      rs1_addr = 5'd5; rs1_rd_en = 1'b1; rs2_addr = 5'd10; rs2_rd_en = 1'b1;
      #2;
      chk("post_rst_x5", {32'h0, rs1_data}, 64'h0);
      chk("post_rst_busy10", {63'h0, rs2_busy}, 64'h0);
      @(negedge clk);
      idle();
      rs1_addr = 5'd9; rs1_rd_en = 1'b1;
      #2;
      chk("first_write_after_rst", {32'h0, nb_rs1_data}, 64'h77);

      // randomized run against the reference model
      @(negedge clk);
      idle();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         we = 2'($urandom_range(0, 3));
         clr = 2'($urandom_range(0, 3));
         a0 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         a1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         d0 = $urandom; d1 = $urandom;
         iss_en = 1'($urandom_range(0, 1));
         iss_rd = 5'($urandom_range(0, 7));
         flush = ($urandom_range(0, 15) == 0);
         rs1_addr = 5'($urandom_range(0, 7)); rs1_rd_en = ($urandom_range(0, 3) != 0);
         rs2_addr = 5'($urandom_range(0, 31)); rs2_rd_en = ($urandom_range(0, 3) != 0);
         model_pend();
         #2;
         chk("rnd_rs1_data", {32'h0, rs1_data}, {32'h0, exp_data(rs1_addr, rs1_rd_en, 1'b1)});
         chk("rnd_rs1_busy", {63'h0, rs1_busy}, {63'h0, exp_busy(rs1_addr, rs1_rd_en, 1'b1)});
         chk("rnd_rs2_data", {32'h0, rs2_data}, {32'h0, exp_data(rs2_addr, rs2_rd_en, 1'b1)});
         chk("rnd_rs2_busy", {63'h0, rs2_busy}, {63'h0, exp_busy(rs2_addr, rs2_rd_en, 1'b1)});
         chk("rnd_busy_vec", {32'h0, busy_vec}, {32'h0, exp_vec()});
         chk("rnd_nb_rs1_data", {32'h0, nb_rs1_data}, {32'h0, exp_data(rs1_addr, rs1_rd_en, 1'b0)});
         chk("rnd_nb_rs2_data", {32'h0, nb_rs2_data}, {32'h0, exp_data(rs2_addr, rs2_rd_en, 1'b0)});
         chk("rnd_nb_rs1_busy", {63'h0, nb_rs1_busy}, {63'h0, exp_busy(rs1_addr, rs1_rd_en, 1'b0)});
         chk("rnd_nb_rs2_busy", {63'h0, nb_rs2_busy}, {63'h0, exp_busy(rs2_addr, rs2_rd_en, 1'b0)});
         chk("rnd_nb_busy_vec", {32'h0, nb_busy_vec}, {32'h0, exp_vec()});
         model_commit();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
